lcv_mul32_seq_del: RTL and testbench
====================================

// Module: lcv_mul32_seq_del
// PURPOSE
// - Sequenced 32x32->64 multiplier built on one pipelined 17x17 signed multiply-accumulate stage.
// - Splits operands into 16-bit halves and issues four partial products, one per cycle.
// - Accumulates the shifted products into a 64-bit result.
// - Sits upstream of the DSP multiply-accumulate primitives and feeds them.
// - Consumed by the integer execute stage through a valid/ready pair.
// PARAMETERS
// - none: widths fixed; operand 32, half 16, partial product 34 signed, result 64.
// PORTS
// clk            in   1   clock, all logic on posedge
// rst            in   1   synchronous, active-low reset (sampled on posedge clk, asserted when 0)
// inp_valid      in   1   request valid
// inp_ready      out  1   block can accept a request
// inp_a          in   32  multiplicand
// inp_b          in   32  multiplier
// inp_signed     in   1   1: operands two's complement; 0: unsigned
// outp_valid     out  1   outp_prod valid
// outp_ready     in   1   consumer accepts outp_prod
// outp_prod      out  64  full product (low 64 bits of exact product)
// BEHAVIOUR
// - Reset (rst==0 at posedge):
//   - state=IDLE, inp_ready=1, outp_valid=0, outp_prod=0, accumulator=0.
//   - Any in-flight op is discarded, no output.
// - FSM states: IDLE, ISSUE0..ISSUE3, DRAIN, DONE.
// - IDLE:
//   - inp_ready=1.
//   - On inp_valid&&inp_ready: latch a, b and signed flag; clear accumulator; ->ISSUE0.
// - Operand halves (17-bit signed): lo = {1'b0, x[15:0]}; hi = {signed ? x[31] : 1'b0, x[31:16]}.
// - Issue order, one per cycle:
//   - ISSUE0: lo_a*lo_b, shift 0
//   - ISSUE1: lo_a*hi_b, shift 16
//   - ISSUE2: hi_a*lo_b, shift 16
//   - ISSUE3: hi_a*hi_b, shift 32
//   - Then ->DRAIN.
// - MAC stage latency 1: product issued in cycle N is registered at N+1.
//   - The accumulator adds it at N+1 (sign-extended to 66 bits, shifted).
// - DRAIN: absorbs the last product; outp_prod <= acc[63:0]; ->DONE.
// - DONE:
//   - outp_valid=1; outp_prod held stable until outp_valid&&outp_ready.
//   - On that handshake: ->IDLE, outp_valid=0 next cycle.
// - Latency: accept edge T -> outp_valid high at T+6.
//   - Minimum request spacing is 7 cycles (inp_ready low ISSUE0..DONE).
// - inp_ready is a pure state decode; it does not depend on outp_ready (no comb path).
// - Backpressure: outp_ready low holds DONE indefinitely; inputs ignored meanwhile.
// - Arithmetic: accumulator 66-bit signed; the final sum needs no saturation.
//   - The low 64 bits equal the exact product for both signed and unsigned operands.
// - inp_a, inp_b and inp_signed are don't-care except on the accept cycle.
// STRUCTURE
// - Package lcv_mul_pkg:
//   - typedef enum for FSM states
//   - localparams: half width 16, pp width 34, result width 64
//   - typedef struct for latched request {a, b, signed}
// - Sub-module lcv_mul17_acc_del1:
//   - registered 17x17 signed multiply, 34-bit out, use_dsp
//   - the accumulate adder stays in this block
// TESTING
// - unsigned 0xFFFF_FFFF*0xFFFF_FFFF -> outp_prod=0xFFFF_FFFE_0000_0001 at T+6
// - signed 0xFFFF_FFFF*0xFFFF_FFFF (-1*-1) -> 0x0000_0000_0000_0001
// - signed 0x8000_0000*0x8000_0000 -> 0x4000_0000_0000_0000
// - signed 0xFFFF_FFFE*0x0000_0003 -> 0xFFFF_FFFF_FFFF_FFFA
//   - same operands unsigned -> 0x0000_0002_FFFF_FFFA
// - outp_ready low for 10 cycles in DONE:
//   - outp_valid and outp_prod stay stable, inp_ready stays 0
//   - handshake then inp_ready=1 next cycle
// - rst=0 during ISSUE2 -> next cycle IDLE, inp_ready=1, outp_valid=0
//   - a following op 3*5 returns 15
// - random signed/unsigned stream with random outp_ready -> matches reference model; no drops

Source files
------------

// File: rtl/lcv_mul_pkg.sv
// Shared types and constants for the sequenced 32x32 multiplier.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package lcv_mul_pkg;

  localparam int OP_W   = 32;
  localparam int HALF_W = 16;
  localparam int PP_W   = 34;
  localparam int RES_W  = 64;
  localparam int ACC_W  = 66;

  // Shift selector for a partial product entering the accumulator
  localparam logic [1:0] SH_0  = 2'd0;
  localparam logic [1:0] SH_16 = 2'd1;
  localparam logic [1:0] SH_32 = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE0,
    ST_ISSUE1,
    ST_ISSUE2,
    ST_ISSUE3,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            sgn;
  } req_t;

  // 17-bit signed operand half: the low half is always non-negative; the high
  // half carries the operand sign only for two's complement requests.
  function automatic logic [HALF_W:0] half_op(input logic [OP_W-1:0] x,
                                              input logic hi,
                                              input logic sgn);
    if (hi) return {sgn & x[OP_W-1], x[OP_W-1:HALF_W]};
    else    return {1'b0, x[HALF_W-1:0]};
  endfunction

endpackage

// File: rtl/lcv_mul17_acc_del1.sv
// 17x17 signed multiply with registered product and shifted 66-bit accumulate.
// Latency: product registered one cycle after issue; accumulated the cycle after.
// Backpressure: none; caller issues at most one product per cycle.
module lcv_mul17_acc_del1
  import lcv_mul_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue,
  input  logic [1:0]              shift_sel,
  input  logic signed [HALF_W:0]  op_a,
  input  logic signed [HALF_W:0]  op_b,
  input  logic                    clear,
  output logic [RES_W-1:0]        sum
);

  (* use_dsp = "yes" *) logic signed [PP_W-1:0] pp;
  logic                    pp_vld;
  logic [1:0]              pp_sh;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] pp_ext;
  logic signed [ACC_W-1:0] pp_shifted;
  logic signed [ACC_W-1:0] acc_nxt;

  // Product register: multiply stage, tagged with its valid and shift amount
  always_ff @(posedge clk) begin
    if (!rst) begin
      pp     <= '0;
      pp_vld <= 1'b0;
      pp_sh  <= SH_0;
    end else begin
      pp     <= op_a * op_b;
      pp_vld <= issue;
      pp_sh  <= shift_sel;
    end
  end

  // Sign-extend and align the registered product, then add it in
  always_comb begin
    pp_ext = {{(ACC_W-PP_W){pp[PP_W-1]}}, pp};
    case (pp_sh)
      SH_16:   pp_shifted = pp_ext <<< 16;
      SH_32:   pp_shifted = pp_ext <<< 32;
      default: pp_shifted = pp_ext;
    endcase
    acc_nxt = pp_vld ? (acc + pp_shifted) : acc;
    sum     = acc_nxt[RES_W-1:0];
  end

  // Accumulator: cleared when a new request is accepted
  always_ff @(posedge clk) begin
    if (!rst)       acc <= '0;
    else if (clear) acc <= '0;
    else            acc <= acc_nxt;
  end

endmodule

// File: rtl/lcv_mul32_seq_del.sv
// Sequenced 32x32->64 multiplier issuing four 17x17 partial products.
// Latency: accept cycle T, result valid in cycle T+6; one request per 7 cycles.
// Backpressure: result held in DONE while outp_ready is low; inputs ignored.
module lcv_mul32_seq_del
  import lcv_mul_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inp_valid,
  output logic             inp_ready,
  input  logic [OP_W-1:0]  inp_a,
  input  logic [OP_W-1:0]  inp_b,
  input  logic             inp_signed,
  output logic             outp_valid,
  input  logic             outp_ready,
  output logic [RES_W-1:0] outp_prod
);

  state_t                 state;
  req_t                   req;
  logic                   issue;
  logic [1:0]             shift_sel;
  logic signed [HALF_W:0] op_a;
  logic signed [HALF_W:0] op_b;
  logic                   clear;
  logic [RES_W-1:0]       sum;

  // Operand half selection for the partial product issued this cycle
  always_comb begin
    issue     = 1'b0;
    shift_sel = SH_0;
    op_a      = '0;
    op_b      = '0;
    case (state)
      ST_ISSUE0: begin
        issue = 1'b1; shift_sel = SH_0;
        op_a  = half_op(req.a, 1'b0, req.sgn);
        op_b  = half_op(req.b, 1'b0, req.sgn);
      end
      ST_ISSUE1: begin
        issue = 1'b1; shift_sel = SH_16;
        op_a  = half_op(req.a, 1'b0, req.sgn);
        op_b  = half_op(req.b, 1'b1, req.sgn);
      end
      ST_ISSUE2: begin
        issue = 1'b1; shift_sel = SH_16;
        op_a  = half_op(req.a, 1'b1, req.sgn);
        op_b  = half_op(req.b, 1'b0, req.sgn);
      end
      ST_ISSUE3: begin
        issue = 1'b1; shift_sel = SH_32;
        op_a  = half_op(req.a, 1'b1, req.sgn);
        op_b  = half_op(req.b, 1'b1, req.sgn);
      end
      default: ;
    endcase
    clear = (state == ST_IDLE) && inp_valid && inp_ready;
  end

  lcv_mul17_acc_del1 u_mac (
    .clk       (clk),
    .rst       (rst),
    .issue     (issue),
    .shift_sel (shift_sel),
    .op_a      (op_a),
    .op_b      (op_b),
    .clear     (clear),
    .sum       (sum)
  );

  // Sequencer FSM with registered handshake outputs and result
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      req        <= '0;
      inp_ready  <= 1'b1;
      outp_valid <= 1'b0;
      outp_prod  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (inp_valid && inp_ready) begin
            req       <= '{a: inp_a, b: inp_b, sgn: inp_signed};
            inp_ready <= 1'b0;
            state     <= ST_ISSUE0;
          end
        end
        ST_ISSUE0: state <= ST_ISSUE1;
        ST_ISSUE1: state <= ST_ISSUE2;
        ST_ISSUE2: state <= ST_ISSUE3;
        ST_ISSUE3: state <= ST_DRAIN;
        ST_DRAIN: begin
          // sum already includes the last product landing this cycle
          outp_prod  <= sum;
          outp_valid <= 1'b1;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          if (outp_ready) begin
            outp_valid <= 1'b0;
            inp_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          inp_ready  <= 1'b1;
          outp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcv_mul32_seq_del.sv
// Directed and random checks of the sequenced multiplier against a 64-bit model.
// Latency: results checked at the sixth cycle after the accept cycle.
// Backpressure: consumer ready held low for varying spans.
module tb_lcv_mul32_seq_del;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inp_valid = 1'b0;
  logic        inp_ready;
  logic [31:0] inp_a = '0;
  logic [31:0] inp_b = '0;
  logic        inp_signed = 1'b0;
  logic        outp_valid;
  logic        outp_ready = 1'b0;
  logic [63:0] outp_prod;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  lcv_mul32_seq_del dut (
    .clk        (clk),
    .rst        (rst),
    .inp_valid  (inp_valid),
    .inp_ready  (inp_ready),
    .inp_a      (inp_a),
    .inp_b      (inp_b),
    .inp_signed (inp_signed),
    .outp_valid (outp_valid),
    .outp_ready (outp_ready),
    .outp_prod  (outp_prod)
  );

  // Reference: widen both operands to 64 bits, multiply, keep the low 64
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic [63:0] x, y;
    x = s ? {{32{a[31]}}, a} : {32'b0, a};
    y = s ? {{32{b[31]}}, b} : {32'b0, b};
    return x * y;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted (bounded)
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input bit push);
    int n = 0;
    while (!inp_ready && n < 50) begin
      tick();
      n++;
    end
    if (!inp_ready) chk("accept_timeout", {63'b0, inp_ready}, 64'd1);
    inp_a = a; inp_b = b; inp_signed = s; inp_valid = 1'b1;
    tick();
    inp_valid = 1'b0;
    inp_a = $urandom; inp_b = $urandom; inp_signed = 1'($urandom);
    if (push) exp_q.push_back(ref_mul(a, b, s));
  endtask

  // Wait for a result, hold it for 'hold' cycles, then take it
  task automatic recv(input int hold);
    int n = 0;
    logic [63:0] e;
    while (!outp_valid && n < 20) begin
      tick();
      n++;
    end
    if (!outp_valid) begin
      chk("result_timeout", {63'b0, outp_valid}, 64'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      chk("unexpected_result", 64'd1, 64'd0);
      e = 'x;
    end else begin
      e = exp_q.pop_front();
    end
    chk("prod", outp_prod, e);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", {63'b0, outp_valid}, 64'd1);
      chk("hold_prod", outp_prod, e);
      chk("hold_ready", {63'b0, inp_ready}, 64'd0);
    end
    outp_ready = 1'b1;
    tick();
    outp_ready = 1'b0;
    inp_valid  = 1'b0;
    chk("valid_drop", {63'b0, outp_valid}, 64'd0);
    chk("ready_back", {63'b0, inp_ready}, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    chk("rst_ready", {63'b0, inp_ready}, 64'd1);
    chk("rst_valid", {63'b0, outp_valid}, 64'd0);
    chk("rst_prod", outp_prod, 64'd0);

    // Latency: valid low through DRAIN, high in the sixth cycle after accept
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    chk("accept_ready_low", {63'b0, inp_ready}, 64'd0);
    repeat (4) tick();
    chk("lat_valid_early", {63'b0, outp_valid}, 64'd0);
    tick();
    chk("lat_valid_on_time", {63'b0, outp_valid}, 64'd1);
    chk("uns_ffff_const", outp_prod, 64'hFFFF_FFFE_0000_0001);
    recv(0);

    // Directed signed/unsigned corner cases
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    recv(0);
    send(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
    repeat (5) tick();
    chk("sgn_min_const", outp_prod, 64'h4000_0000_0000_0000);
    recv(0);
    send(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b1);
    repeat (5) tick();
    chk("sgn_neg2x3_const", outp_prod, 64'hFFFF_FFFF_FFFF_FFFA);
    recv(0);
    send(32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 1'b1);
    repeat (5) tick();
    chk("uns_neg2x3_const", outp_prod, 64'h0000_0002_FFFF_FFFA);
    recv(0);

    // Backpressure for 10 cycles with a competing request on the input
    send(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1);
    repeat (5) tick();
    inp_valid = 1'b1; inp_a = 32'd7; inp_b = 32'd9; inp_signed = 1'b0;
    recv(10);
    tick();
    chk("no_ghost_accept", {63'b0, inp_ready}, 64'd1);

    // Reset in ISSUE2 discards the op
    send(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_ready", {63'b0, inp_ready}, 64'd1);
    chk("midrst_valid", {63'b0, outp_valid}, 64'd0);
    repeat (6) tick();
    chk("midrst_no_output", {63'b0, outp_valid}, 64'd0);
    send(32'd3, 32'd5, 1'b0, 1'b1);
    repeat (5) tick();
    chk("after_rst_3x5", outp_prod, 64'd15);
    recv(0);

    // Random stream with random consumer stalls
    for (int k = 0; k < 24; k++) begin
      logic [31:0] a, b;
      logic s;
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      if (k % 6 == 1) a = 32'h8000_0000;
      if (k % 6 == 3) b = 32'h0000_FFFF;
      if (k % 6 == 5) a = 32'h0001_0000;
      send(a, b, s, 1'b1);
      recv($urandom_range(0, 3));
    end
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
